// File: rtl/qar_rf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : qar_rf_pkg
// Purpose  : Shared defaults and helpers for the QAR-Core multi-port
//            register file (address width, packed read-port slicing).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package qar_rf_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  // Register-address width for a file of n registers (n is a power of two, >= 2).
  function automatic int addr_width(input int n);
    return $clog2(n);
  endfunction

  // LSB of field k inside a packed per-port bus whose fields are w bits wide.
  function automatic int port_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : rf_scoreboard
// Purpose  : One busy bit per architectural register, used for load-use and
//            long-latency hazard detection.
// Ports    : clk, rst_n          - clock, async active-low reset
//            wr0_en/wr0_addr     - write port 0 (already zero-reg filtered)
//            wr1_en/wr1_addr     - write port 1 (already zero-reg filtered)
//            issue_en/issue_addr - mark a destination as pending
//            flush               - clear every busy bit
//            busy                - busy bit vector, one bit per register
// Revision : 1.0 - initial release
// ============================================================================
module rf_scoreboard
  import qar_rf_pkg::*;
#(
  parameter int NREGS    = NREGS_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr0_en,
  input  logic [$clog2(NREGS)-1:0]   wr0_addr,
  input  logic                       wr1_en,
  input  logic [$clog2(NREGS)-1:0]   wr1_addr,
  input  logic                       issue_en,
  input  logic [$clog2(NREGS)-1:0]   issue_addr,
  input  logic                       flush,
  output logic [NREGS-1:0]           busy
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      // Flush wins over a same-cycle issue.
      busy_d = '0;
    end else begin
      if (wr0_en) busy_d[wr0_addr] = 1'b0;
      if (wr1_en) busy_d[wr1_addr] = 1'b0;
      // Applied after the clears: an issue is newer than a completing write.
      if (issue_en) busy_d[issue_addr] = 1'b1;
    end
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Purpose  : Parametrised multi-port integer register file with two write
//            ports, optional write-to-read bypass, optional hardwired x0 and
//            a per-register busy scoreboard.
// Ports    : clk, rst_n                   - clock, async active-low reset
//            wr0_en/wr0_addr/wr0_data     - write port 0
//            wr1_en/wr1_addr/wr1_data     - write port 1 (wins collisions)
//            rd_addr  [NRD*AW]            - packed read addresses
//            rd_data  [NRD*XLEN]          - packed read data (combinational)
//            rd_busy  [NRD]               - per-read-port hazard flag
//            issue_en/issue_addr          - mark destination pending
//            flush                        - clear all busy bits
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp
  import qar_rf_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NRD      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            wr0_en,
  input  logic [$clog2(NREGS)-1:0]        wr0_addr,
  input  logic [XLEN-1:0]                 wr0_data,
  input  logic                            wr1_en,
  input  logic [$clog2(NREGS)-1:0]        wr1_addr,
  input  logic [XLEN-1:0]                 wr1_data,
  input  logic [NRD*$clog2(NREGS)-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]             rd_data,
  output logic [NRD-1:0]                  rd_busy,
  input  logic                            issue_en,
  input  logic [$clog2(NREGS)-1:0]        issue_addr,
  input  logic                            flush
);

  localparam int AW = addr_width(NREGS);

  logic [NREGS-1:0][XLEN-1:0] regs_q;
  logic [NREGS-1:0][XLEN-1:0] regs_d;
  logic [NREGS-1:0]           busy_vec;

  // Effective enables: writes and issues to x0 vanish when x0 is hardwired.
  logic wr0_eff;
  logic wr1_eff;
  logic issue_eff;

  assign wr0_eff   = wr0_en   && !((ZERO_REG != 0) && (wr0_addr   == '0));
  assign wr1_eff   = wr1_en   && !((ZERO_REG != 0) && (wr1_addr   == '0));
  assign issue_eff = issue_en && !((ZERO_REG != 0) && (issue_addr == '0));

  always_comb begin
    regs_d = regs_q;
    if (wr0_eff) regs_d[wr0_addr] = wr0_data;
    // Port 1 applied last so it wins a same-address collision.
    if (wr1_eff) regs_d[wr1_addr] = wr1_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) regs_q <= '0;
    else        regs_q <= regs_d;
  end

  rf_scoreboard #(
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr0_en     (wr0_eff),
    .wr0_addr   (wr0_addr),
    .wr1_en     (wr1_eff),
    .wr1_addr   (wr1_addr),
    .issue_en   (issue_eff),
    .issue_addr (issue_addr),
    .flush      (flush),
    .busy       (busy_vec)
  );

  generate
    for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data;
      logic            bsy;

      always_comb begin
        addr = rd_addr[port_lsb(k, AW) +: AW];
        data = regs_q[addr];
        bsy  = busy_vec[addr];
        // Forwarding is held off during reset so reads show the cleared state.
        if ((BYPASS != 0) && rst_n) begin
          if (wr1_eff && (wr1_addr == addr)) begin
            data = wr1_data;
            bsy  = 1'b0;
          end else if (wr0_eff && (wr0_addr == addr)) begin
            data = wr0_data;
            bsy  = 1'b0;
          end
        end
        if ((ZERO_REG != 0) && (addr == '0)) begin
          data = '0;
          bsy  = 1'b0;
        end
      end

      assign rd_data[port_lsb(k, XLEN) +: XLEN] = data;
      assign rd_busy[k]                          = bsy;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp
// Purpose  : Self-checking bench for regfile_mp. Two instances share all
//            inputs: one with bypass enabled, one without.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 wr0_en, wr1_en, issue_en, flush;
  logic [AW-1:0]        wr0_addr, wr1_addr, issue_addr;
  logic [XLEN-1:0]      wr0_data, wr1_data;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*XLEN-1:0]  rd_data, rd_data_nb;
  logic [NRD-1:0]       rd_busy, rd_busy_nb;

  int checks = 0;
  int errors = 0;

  // Architectural reference state.
  logic [XLEN-1:0] m_mem  [NREGS];
  bit              m_busy [NREGS];

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .issue_en(issue_en), .issue_addr(issue_addr), .flush(flush)
  );

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(0), .ZERO_REG(1)) dut_nb (
    .clk(clk), .rst_n(rst_n),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .issue_en(issue_en), .issue_addr(issue_addr), .flush(flush)
  );

  // ---------------- reference model ----------------
  function automatic void m_clear();
    for (int i = 0; i < NREGS; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endfunction

  function automatic void m_edge();
    if (!rst_n) begin
      m_clear();
      return;
    end
    if (wr0_en && wr0_addr != 0) m_mem[wr0_addr] = wr0_data;
    if (wr1_en && wr1_addr != 0) m_mem[wr1_addr] = wr1_data;
    if (flush) begin
      for (int i = 0; i < NREGS; i++) m_busy[i] = 1'b0;
    end else begin
      if (wr0_en) m_busy[wr0_addr] = 1'b0;
      if (wr1_en) m_busy[wr1_addr] = 1'b0;
      if (issue_en && issue_addr != 0) m_busy[issue_addr] = 1'b1;
    end
  endfunction

  function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a, input bit byp);
    if (a == 0) return '0;
    if (byp && rst_n) begin
      if (wr1_en && wr1_addr == a) return wr1_data;
      if (wr0_en && wr0_addr == a) return wr0_data;
    end
    return m_mem[a];
  endfunction

  function automatic bit exp_busy(input logic [AW-1:0] a, input bit byp);
    if (a == 0) return 1'b0;
    if (byp && rst_n && ((wr1_en && wr1_addr == a) || (wr0_en && wr0_addr == a))) return 1'b0;
    return m_busy[a];
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    wr0_en = 0; wr1_en = 0; issue_en = 0; flush = 0;
    wr0_addr = '0; wr1_addr = '0; issue_addr = '0;
    wr0_data = '0; wr1_data = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    m_edge();
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 0; idle(); rd_addr = {5'd3, 5'd1}; m_clear();
    #2;
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", rd_data); end
    checks++; if (rd_busy !== '0) begin errors++; $display("FAIL reset_busy: got %b expected 0", rd_busy); end
    checks++; if (rd_data_nb !== '0) begin errors++; $display("FAIL reset_data_nb: got %h expected 0", rd_data_nb); end
    tick(); tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_reset_midrun();
    wr0_en = 1; wr0_addr = 5; wr0_data = 32'hDEADBEEF;
    issue_en = 1; issue_addr = 12;
    tick(); idle();
    rd_addr = {5'd12, 5'd5}; #1;
    checks++; if (rd_data[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL midrun_pre_data: got %h expected deadbeef", rd_data[31:0]); end
    checks++; if (rd_busy[1] !== 1'b1) begin errors++; $display("FAIL midrun_pre_busy: got %b expected 1", rd_busy[1]); end
    wr1_en = 1; wr1_addr = 5; wr1_data = 32'h55AA55AA;
    rst_n = 0; m_clear(); #1;
    checks++; if (rd_data[31:0] !== 32'h0) begin errors++; $display("FAIL midrun_rst_data: got %h expected 0", rd_data[31:0]); end
    checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL midrun_rst_busy: got %b expected 00", rd_busy); end
    checks++; if (rd_data_nb[31:0] !== 32'h0) begin errors++; $display("FAIL midrun_rst_data_nb: got %h expected 0", rd_data_nb[31:0]); end
    tick(); idle();
    rst_n = 1; #1;
    checks++; if (rd_data[31:0] !== 32'h0 || rd_busy !== 2'b00) begin errors++; $display("FAIL midrun_after: got %h/%b expected 0/00", rd_data[31:0], rd_busy); end
    tick();
  endtask

  task automatic test_collision();
    wr0_en = 1; wr0_addr = 7; wr0_data = 32'h11111111;
    wr1_en = 1; wr1_addr = 7; wr1_data = 32'h22222222;
    rd_addr = {5'd0, 5'd7}; #1;
    checks++; if (rd_data[31:0] !== 32'h22222222) begin errors++; $display("FAIL coll_bypass: got %h expected 22222222", rd_data[31:0]); end
    tick(); idle(); #1;
    checks++; if (rd_data[31:0] !== 32'h22222222) begin errors++; $display("FAIL coll_data: got %h expected 22222222", rd_data[31:0]); end
    checks++; if (rd_data_nb[31:0] !== 32'h22222222) begin errors++; $display("FAIL coll_data_nb: got %h expected 22222222", rd_data_nb[31:0]); end
  endtask

  task automatic test_bypass();
    wr0_en = 1; wr0_addr = 3; wr0_data = 32'h0BADF00D;
    issue_en = 1; issue_addr = 3;
    tick(); idle();
    wr0_en = 1; wr0_addr = 3; wr0_data = 32'hA5A5A5A5;
    rd_addr = {5'd0, 5'd3}; #1;
    checks++; if (rd_data[31:0] !== 32'hA5A5A5A5) begin errors++; $display("FAIL bypass_data: got %h expected a5a5a5a5", rd_data[31:0]); end
    checks++; if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL bypass_busy: got %b expected 0", rd_busy[0]); end
    checks++; if (rd_data_nb[31:0] !== 32'h0BADF00D) begin errors++; $display("FAIL nobypass_data: got %h expected 0badf00d", rd_data_nb[31:0]); end
    checks++; if (rd_busy_nb[0] !== 1'b1) begin errors++; $display("FAIL nobypass_busy: got %b expected 1", rd_busy_nb[0]); end
    tick(); idle(); #1;
    checks++; if (rd_data_nb[31:0] !== 32'hA5A5A5A5 || rd_busy_nb[0] !== 1'b0) begin errors++; $display("FAIL bypass_after: got %h/%b expected a5a5a5a5/0", rd_data_nb[31:0], rd_busy_nb[0]); end
  endtask

  task automatic test_zero_reg();
    wr0_en = 1; wr0_addr = 0; wr0_data = 32'h12345678;
    wr1_en = 1; wr1_addr = 0; wr1_data = 32'h87654321;
    issue_en = 1; issue_addr = 0;
    rd_addr = {5'd0, 5'd0}; #1;
    checks++; if (rd_data !== '0 || rd_busy !== 2'b00) begin errors++; $display("FAIL zero_same: got %h/%b expected 0/00", rd_data, rd_busy); end
    tick(); idle(); #1;
    checks++; if (rd_data !== '0 || rd_busy !== 2'b00) begin errors++; $display("FAIL zero_after: got %h/%b expected 0/00", rd_data, rd_busy); end
    checks++; if (rd_data_nb !== '0 || rd_busy_nb !== 2'b00) begin errors++; $display("FAIL zero_after_nb: got %h/%b expected 0/00", rd_data_nb, rd_busy_nb); end
  endtask

  task automatic test_scoreboard();
    issue_en = 1; issue_addr = 9;
    tick(); idle();
    rd_addr = {5'd9, 5'd9}; #1;
    checks++; if (rd_busy !== 2'b11) begin errors++; $display("FAIL sb_set: got %b expected 11", rd_busy); end
    wr1_en = 1; wr1_addr = 9; wr1_data = 32'hC0FFEE01; #1;
    checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL sb_bypass_clear: got %b expected 00", rd_busy); end
    checks++; if (rd_busy_nb !== 2'b11) begin errors++; $display("FAIL sb_nb_still: got %b expected 11", rd_busy_nb); end
    tick(); idle(); #1;
    checks++; if (rd_busy_nb !== 2'b00) begin errors++; $display("FAIL sb_clear: got %b expected 00", rd_busy_nb); end
    issue_en = 1; issue_addr = 9;
    wr0_en = 1; wr0_addr = 9; wr0_data = 32'hC0FFEE02;
    tick(); idle(); #1;
    checks++; if (rd_busy !== 2'b11) begin errors++; $display("FAIL sb_issue_wins: got %b expected 11", rd_busy); end
    checks++; if (rd_data[63:32] !== 32'hC0FFEE02) begin errors++; $display("FAIL sb_issue_data: got %h expected c0ffee02", rd_data[63:32]); end
  endtask

  task automatic test_flush();
    logic [AW-1:0] fl_addr [4];
    fl_addr[0] = 4; fl_addr[1] = 6; fl_addr[2] = 8; fl_addr[3] = 10;
    for (int i = 0; i < 3; i++) begin
      issue_en = 1; issue_addr = fl_addr[i];
      tick();
    end
    idle();
    flush = 1; issue_en = 1; issue_addr = 10;
    rd_addr = {5'd8, 5'd4}; #1;
    checks++; if (rd_busy !== 2'b11) begin errors++; $display("FAIL flush_pre: got %b expected 11", rd_busy); end
    tick(); idle();
    for (int i = 0; i < 4; i++) begin
      rd_addr = {fl_addr[i], fl_addr[i]}; #1;
      checks++; if (rd_busy !== 2'b00 || rd_busy_nb !== 2'b00) begin errors++; $display("FAIL flush_x%0d: got %b/%b expected 00", fl_addr[i], rd_busy, rd_busy_nb); end
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    for (int c = 0; c < 400; c++) begin
      wr0_en     = 1'($urandom_range(0, 1));
      wr0_addr   = AW'($urandom_range(0, 7));
      wr0_data   = $urandom;
      wr1_en     = 1'($urandom_range(0, 1));
      wr1_addr   = AW'($urandom_range(0, 7));
      wr1_data   = $urandom;
      issue_en   = ($urandom_range(0, 2) != 0);
      issue_addr = AW'($urandom_range(0, 7));
      flush      = ($urandom_range(0, 15) == 0);
      rd_addr    = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      #1;
      for (int k = 0; k < NRD; k++) begin
        a = rd_addr[k*AW +: AW];
        checks++; if (rd_data[k*XLEN +: XLEN] !== exp_data(a, 1)) begin errors++; $display("FAIL rand_data c%0d p%0d: got %h expected %h", c, k, rd_data[k*XLEN +: XLEN], exp_data(a, 1)); end
        checks++; if (rd_busy[k] !== exp_busy(a, 1)) begin errors++; $display("FAIL rand_busy c%0d p%0d: got %b expected %b", c, k, rd_busy[k], exp_busy(a, 1)); end
        checks++; if (rd_data_nb[k*XLEN +: XLEN] !== exp_data(a, 0)) begin errors++; $display("FAIL rand_data_nb c%0d p%0d: got %h expected %h", c, k, rd_data_nb[k*XLEN +: XLEN], exp_data(a, 0)); end
        checks++; if (rd_busy_nb[k] !== exp_busy(a, 0)) begin errors++; $display("FAIL rand_busy_nb c%0d p%0d: got %b expected %b", c, k, rd_busy_nb[k], exp_busy(a, 0)); end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_reset_midrun();
    test_collision();
    test_bypass();
    test_zero_reg();
    test_scoreboard();
    test_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
